// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths and types for writeback, register file and issue logic.
package regfile_pkg;
    localparam int XLEN = 32;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS = 32;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requester bus plus the registered register-file write port.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
);
    logic [NUM_REQ-1:0]                               i_req_valid;
    logic [NUM_REQ-1:0][regfile_pkg::REG_IDX_W-1:0]   i_req_index;
    logic [NUM_REQ-1:0][XLEN-1:0]                     i_req_data;
    logic [NUM_REQ-1:0]                               o_req_ready;
    logic                                             o_write_enable;
    logic [regfile_pkg::REG_IDX_W-1:0]                o_write_index;
    logic [XLEN-1:0]                                  o_write_data;
    modport master (
        output i_req_valid, i_req_index, i_req_data,
        input  o_req_ready, o_write_enable, o_write_index, o_write_data
    );
    modport slave (
        input  i_req_valid, i_req_index, i_req_data,
        output o_req_ready, o_write_enable, o_write_index, o_write_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; the pointer moves past the winner on each advance.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant
);
    localparam int PW = $clog2(NUM_REQ);
    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            idx;
    always_comb begin
        o_grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && i_req[idx]) begin
                o_grant[idx] = 1'b1;
                found = 1'b1;
                ptr_d = i_advance ? PW'((idx + 1) % NUM_REQ) : ptr_q;
            end
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter, registered write port and RAW scoreboard.
// Define RF_WB_FORWARD_EN to add write-cycle forwarding outputs.
module regfile_wb_arbiter import regfile_pkg::*; #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = regfile_pkg::XLEN
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    regfile_wb_arbiter_if.slave  bus,
    input  logic                 i_issue_valid,
    input  reg_idx_t             i_issue_index,
    input  reg_idx_t             i_check_index1,
    input  reg_idx_t             i_check_index2,
    output logic                 o_busy1,
    output logic                 o_busy2
`ifdef RF_WB_FORWARD_EN
    ,
    output logic                 o_fwd_hit1,
    output logic                 o_fwd_hit2,
    output logic [XLEN-1:0]      o_fwd_data1,
    output logic [XLEN-1:0]      o_fwd_data2
`endif
);
    logic [NUM_REQ-1:0]  grant;
    logic                xfer;
    reg_idx_t            sel_idx;
    logic [XLEN-1:0]     sel_data;
    logic                we_q, we_d;
    reg_idx_t            widx_q, widx_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (bus.i_req_valid),
        .i_advance (xfer),
        .o_grant   (grant)
    );

    assign xfer = |grant;
    assign bus.o_req_ready = grant;
    assign bus.o_write_enable = we_q;
    assign bus.o_write_index = widx_q;
    assign bus.o_write_data = wdata_q;

    always_comb begin
        sel_idx = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_idx = bus.i_req_index[k];
                sel_data = bus.i_req_data[k];
            end
        end
    end

    // x0 requests are consumed but never reach the register file
    always_comb begin
        we_d = xfer && sel_idx != '0;
        widx_d = xfer ? sel_idx : widx_q;
        wdata_d = xfer ? sel_data : wdata_q;
        busy_d = busy_q;
        if (we_q) busy_d[widx_q] = 1'b0;
        if (i_issue_valid) busy_d[i_issue_index] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            we_q    <= 1'b0;
            widx_q  <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            we_q    <= we_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

`ifdef RF_WB_FORWARD_EN
    assign o_fwd_hit1 = we_q && widx_q == i_check_index1 && i_check_index1 != '0;
    assign o_fwd_hit2 = we_q && widx_q == i_check_index2 && i_check_index2 != '0;
    assign o_fwd_data1 = wdata_q;
    assign o_fwd_data2 = wdata_q;
    // a forwarded source is free unless this very cycle issues a new producer of it
    assign o_busy1 = o_fwd_hit1 ? (i_issue_valid && i_issue_index == i_check_index1) : busy_q[i_check_index1];
    assign o_busy2 = o_fwd_hit2 ? (i_issue_valid && i_issue_index == i_check_index2) : busy_q[i_check_index2];
`else
    assign o_busy1 = busy_q[i_check_index1];
    assign o_busy2 = busy_q[i_check_index2];
`endif
endmodule
